// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_ctrl
// Brief    : Command sequencer driving a universal shift register through one
//            parallel load followed by N shift cycles, then reporting result.
// Revision : 1.0
// ============================================================================
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic             cmd_rot,
    input  logic [WIDTH-1:0] reg_q,
    output logic [1:0]       reg_s,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_shift_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] c_MODE_HOLD  = 2'b00;
    localparam logic [1:0] c_MODE_LOAD  = 2'b01;
    localparam logic [1:0] c_MODE_MSB   = 2'b10;
    localparam logic [1:0] c_MODE_LSB   = 2'b11;
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_dir;
    logic [CNT_W-1:0] r_count;
    logic             r_fill;
    logic             r_rot;
    logic [CNT_W-1:0] r_remaining;
    logic [WIDTH-1:0] r_result;
    logic             w_accept;

    // Ready is forced low while reset is asserted so no command slips in on the reset edge.
    assign cmd_ready = (r_state == S_IDLE) && !reset;
    assign w_accept  = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_data      <= '0;
            r_dir       <= 1'b0;
            r_count     <= '0;
            r_fill      <= 1'b0;
            r_rot       <= 1'b0;
            r_remaining <= '0;
            r_result    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data  <= cmd_data;
                        r_dir   <= cmd_dir;
                        r_count <= cmd_count;
                        r_fill  <= cmd_fill;
                        r_rot   <= cmd_rot;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_count == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_remaining <= r_count;
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // remaining is at least 1 here, so the decrement never wraps.
                    r_remaining <= r_remaining - c_ONE;
                    if (r_remaining == c_ONE) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_result <= reg_q;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Register controls decode from state and the captured command only,
    // except the rotate feedback which must track the live register value.
    always_comb begin
        reg_s        = c_MODE_HOLD;
        reg_d        = '0;
        reg_shift_in = 1'b0;
        case (r_state)
            S_LOAD: begin
                reg_s = c_MODE_LOAD;
                reg_d = r_data;
            end
            S_SHIFT: begin
                reg_s = r_dir ? c_MODE_LSB : c_MODE_MSB;
                if (r_rot) begin
                    reg_shift_in = r_dir ? reg_q[0] : reg_q[WIDTH-1];
                end else begin
                    reg_shift_in = r_fill;
                end
            end
            default: begin
                reg_s = c_MODE_HOLD;
            end
        endcase
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_seq_ctrl
// Brief    : Directed self-checking bench for shift_seq_ctrl with a behavioural
//            4-bit universal shift register closing the loop.
// Revision : 1.0
// ============================================================================
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic       cmd_dir;
    logic [2:0] cmd_count;
    logic       cmd_fill;
    logic       cmd_rot;
    logic [3:0] reg_q;
    logic [1:0] reg_s;
    logic [3:0] reg_d;
    logic       reg_shift_in;
    logic       busy;
    logic       done;
    logic [3:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    shift_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cmd_dir      (cmd_dir),
        .cmd_count    (cmd_count),
        .cmd_fill     (cmd_fill),
        .cmd_rot      (cmd_rot),
        .reg_q        (reg_q),
        .reg_s        (reg_s),
        .reg_d        (reg_d),
        .reg_shift_in (reg_shift_in),
        .busy         (busy),
        .done         (done),
        .result       (result)
    );

    always #5 clk = ~clk;

    // Universal shift register: 00 hold, 01 load, 10 toward MSB, 11 toward LSB.
    logic [3:0] q = 4'b0000;
    always @(posedge clk) begin
        case (reg_s)
            2'b01:   q <= reg_d;
            2'b10:   q <= {q[2:0], reg_shift_in};
            2'b11:   q <= {reg_shift_in, q[3:1]};
            default: q <= q;
        endcase
    end
    assign reg_q = q;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic [3:0] d, input logic dir,
                           input logic [2:0] cnt, input logic fill, input logic rot);
        cmd_valid = v;
        cmd_data  = d;
        cmd_dir   = dir;
        cmd_count = cnt;
        cmd_fill  = fill;
        cmd_rot   = rot;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_cmd(1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc();
        cyc();
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low: got %b want 0", cmd_ready); end
        reset = 1'b0;
        #1;
        n_cmp++; if (reg_s !== 2'b00) begin n_bad++; $display("FAIL reset_reg_s: got %b want 00", reg_s); end
        n_cmp++; if (reg_d !== 4'b0000) begin n_bad++; $display("FAIL reset_reg_d: got %b want 0000", reg_d); end
        n_cmp++; if (reg_shift_in !== 1'b0) begin n_bad++; $display("FAIL reset_shift_in: got %b want 0", reg_shift_in); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (result !== 4'b0000) begin n_bad++; $display("FAIL reset_result: got %b want 0000", result); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_idle: got %b want 1", cmd_ready); end
    endtask

    task automatic test_shift_msb();
        logic [1:0] exp_s [5] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
        set_cmd(1'b1, 4'b1011, 1'b0, 3'd2, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            cmd_valid = 1'b0;
            n_cmp++; if (reg_s !== exp_s[k-1]) begin n_bad++; $display("FAIL msb_reg_s cyc%0d: got %b want %b", k, reg_s, exp_s[k-1]); end
            n_cmp++; if (done !== (k == 4)) begin n_bad++; $display("FAIL msb_done cyc%0d: got %b want %b", k, done, (k == 4)); end
            n_cmp++; if (reg_shift_in !== 1'b0) begin n_bad++; $display("FAIL msb_shift_in cyc%0d: got %b want 0", k, reg_shift_in); end
            if (k == 1) begin
                n_cmp++; if (reg_d !== 4'b1011) begin n_bad++; $display("FAIL msb_reg_d: got %b want 1011", reg_d); end
                n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL msb_ready_load: got %b want 0", cmd_ready); end
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL msb_busy_load: got %b want 1", busy); end
            end
            if (k == 2) begin
                n_cmp++; if (reg_d !== 4'b0000) begin n_bad++; $display("FAIL msb_reg_d_shift: got %b want 0000", reg_d); end
            end
            if (k == 5) begin
                n_cmp++; if (result !== 4'b1100) begin n_bad++; $display("FAIL msb_result: got %b want 1100", result); end
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL msb_busy_idle: got %b want 0", busy); end
            end
        end
    endtask

    task automatic test_fill_lsb();
        logic [1:0] exp_s [6] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
        logic [3:0] exp_q [6] = '{4'b0000, 4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1110};
        set_cmd(1'b1, 4'b0000, 1'b1, 3'd3, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            cmd_valid = 1'b0;
            n_cmp++; if (reg_s !== exp_s[k-1]) begin n_bad++; $display("FAIL fill_reg_s cyc%0d: got %b want %b", k, reg_s, exp_s[k-1]); end
            n_cmp++; if (reg_shift_in !== (k >= 2 && k <= 4)) begin n_bad++; $display("FAIL fill_shift_in cyc%0d: got %b want %b", k, reg_shift_in, (k >= 2 && k <= 4)); end
            if (k >= 3) begin
                n_cmp++; if (reg_q !== exp_q[k-1]) begin n_bad++; $display("FAIL fill_reg_q cyc%0d: got %b want %b", k, reg_q, exp_q[k-1]); end
            end
            n_cmp++; if (done !== (k == 5)) begin n_bad++; $display("FAIL fill_done cyc%0d: got %b want %b", k, done, (k == 5)); end
        end
        n_cmp++; if (result !== 4'b1110) begin n_bad++; $display("FAIL fill_result: got %b want 1110", result); end
    endtask

    task automatic test_count_zero();
        logic [1:0] exp_s [3] = '{2'b01, 2'b00, 2'b00};
        set_cmd(1'b1, 4'b0110, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            cmd_valid = 1'b0;
            n_cmp++; if (reg_s !== exp_s[k-1]) begin n_bad++; $display("FAIL zero_reg_s cyc%0d: got %b want %b", k, reg_s, exp_s[k-1]); end
            n_cmp++; if (done !== (k == 2)) begin n_bad++; $display("FAIL zero_done cyc%0d: got %b want %b", k, done, (k == 2)); end
        end
        n_cmp++; if (result !== 4'b0110) begin n_bad++; $display("FAIL zero_result: got %b want 0110", result); end
    endtask

    task automatic test_rotate();
        logic       exp_si [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        // LSB-ward rotate by one with fill opposite to the rotated-in bit.
        set_cmd(1'b1, 4'b0001, 1'b1, 3'd1, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            cmd_valid = 1'b0;
            if (k == 2) begin
                n_cmp++; if (reg_s !== 2'b11) begin n_bad++; $display("FAIL rotA_reg_s: got %b want 11", reg_s); end
                n_cmp++; if (reg_shift_in !== 1'b1) begin n_bad++; $display("FAIL rotA_shift_in: got %b want 1", reg_shift_in); end
            end
            n_cmp++; if (done !== (k == 3)) begin n_bad++; $display("FAIL rotA_done cyc%0d: got %b want %b", k, done, (k == 3)); end
        end
        n_cmp++; if (result !== 4'b1000) begin n_bad++; $display("FAIL rotA_result: got %b want 1000", result); end

        // MSB-ward rotate by the full width returns the original word.
        set_cmd(1'b1, 4'b1001, 1'b0, 3'd4, 1'b1, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            cyc();
            cmd_valid = 1'b0;
            if (k >= 2 && k <= 5) begin
                n_cmp++; if (reg_shift_in !== exp_si[k-2]) begin n_bad++; $display("FAIL rotB_shift_in cyc%0d: got %b want %b", k, reg_shift_in, exp_si[k-2]); end
            end
            n_cmp++; if (done !== (k == 6)) begin n_bad++; $display("FAIL rotB_done cyc%0d: got %b want %b", k, done, (k == 6)); end
        end
        n_cmp++; if (result !== 4'b1001) begin n_bad++; $display("FAIL rotB_result: got %b want 1001", result); end
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        set_cmd(1'b1, 4'b1100, 1'b1, 3'd1, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (done === 1'b1) n_done++;
            // Second command appears while the first is busy and must not disturb it.
            if (k == 1) set_cmd(1'b1, 4'b0011, 1'b0, 3'd2, 1'b1, 1'b0);
            if (k == 5) cmd_valid = 1'b0;
            n_cmp++; if (cmd_ready !== (k == 4 || k >= 9)) begin n_bad++; $display("FAIL b2b_ready cyc%0d: got %b want %b", k, cmd_ready, (k == 4 || k >= 9)); end
            n_cmp++; if (done !== (k == 3 || k == 8)) begin n_bad++; $display("FAIL b2b_done cyc%0d: got %b want %b", k, done, (k == 3 || k == 8)); end
            if (k == 4) begin
                n_cmp++; if (result !== 4'b0110) begin n_bad++; $display("FAIL b2b_result1: got %b want 0110", result); end
            end
            if (k == 5) begin
                n_cmp++; if (reg_d !== 4'b0011) begin n_bad++; $display("FAIL b2b_reg_d2: got %b want 0011", reg_d); end
            end
        end
        n_cmp++; if (n_done !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
        n_cmp++; if (result !== 4'b1111) begin n_bad++; $display("FAIL b2b_result2: got %b want 1111", result); end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        set_cmd(1'b1, 4'b1010, 1'b0, 3'd5, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            cmd_valid = 1'b0;
            if (done === 1'b1) n_done++;
        end
        n_cmp++; if (reg_s !== 2'b10) begin n_bad++; $display("FAIL rst_mid_in_shift: got %b want 10", reg_s); end
        reset = 1'b1;
        cyc();
        n_cmp++; if (reg_s !== 2'b00) begin n_bad++; $display("FAIL rst_mid_reg_s: got %b want 00", reg_s); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_cmp++; if (result !== 4'b0000) begin n_bad++; $display("FAIL rst_mid_result: got %b want 0000", result); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 0", cmd_ready); end
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (done === 1'b1) n_done++;
            cyc();
        end
        n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL rst_mid_no_done: got %0d want 0", n_done); end

        set_cmd(1'b1, 4'b0101, 1'b1, 3'd2, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            cmd_valid = 1'b0;
            n_cmp++; if (done !== (k == 4)) begin n_bad++; $display("FAIL rst_new_done cyc%0d: got %b want %b", k, done, (k == 4)); end
        end
        n_cmp++; if (result !== 4'b0001) begin n_bad++; $display("FAIL rst_new_result: got %b want 0001", result); end
    endtask

    initial begin
        test_reset();
        test_shift_msb();
        test_fill_lsb();
        test_count_zero();
        test_rotate();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
